serial_tx: RTL and testbench

Parallel-to-serial asynchronous frame transmitter. It is the transmit end of the team's serial link and drives the line that the bit-sampling receiver chain consumes. A byte is accepted from a valid/ready source and shifted out LSB-first as a framed line: start bit, data bits, optional parity bit, stop bit(s). Line idles high.

---
 rtl/serial_tx.sv | 154 +++++++++++++++
 tb/tb_serial_tx.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Line idles high; a byte is taken from a valid/ready source whenever the FSM is idle.
module serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_reg, state_next;
    logic [BAUD_W-1:0]      baud_reg, baud_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   parity_reg, parity_next;
    logic                   tx_reg, tx_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic                   bit_end;

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_reg  <= S_IDLE;
            baud_reg   <= '0;
            idx_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            idx_reg    <= idx_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    // tx is computed from the next state so the line moves on the same edge as the FSM.
    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        idx_next    = idx_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        tx_next     = tx_reg;
        done_next   = 1'b0;
        bit_end     = (baud_reg == BIT_LAST);

        case (state_reg)
            S_IDLE: begin
                tx_next = 1'b1;
                if (data_valid) begin
                    state_next  = S_START;
                    shift_next  = data_in;
                    parity_next = (^data_in) ^ (PARITY_ODD != 0);
                    baud_next   = '0;
                    idx_next    = '0;
                    tx_next     = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                    baud_next  = '0;
                    idx_next   = '0;
                    tx_next    = shift_reg[0];
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (idx_reg == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_next = S_PARITY;
                            tx_next    = parity_reg;
                        end else begin
                            state_next = S_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                        tx_next  = shift_next[0];
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                    baud_next  = '0;
                    tx_next    = 1'b1;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            S_STOP: begin
                // Stop period spans all stop bits in one count.
                if (baud_reg == STOP_LAST) begin
                    state_next = S_IDLE;
                    baud_next  = '0;
                    done_next  = 1'b1;
                    tx_next    = 1'b1;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                baud_next  = '0;
                tx_next    = 1'b1;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    assign data_ready = (state_reg == S_IDLE);
    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: four instances cover plain, even/odd parity and two-stop-bit framing.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       RESET;
    logic [7:0] din [4];
    logic [3:0] dv;
    logic [3:0] rdy_w, tx_w, busy_w, done_w;

    int errors = 0;
    int checks = 0;

    logic obs_tx   [0:199];
    logic obs_busy [0:199];
    logic obs_done [0:199];
    logic obs_rdy  [0:199];
    logic acc_rdy;

    always #5 clk = ~clk;

    // Instance 0: plain, 1: even parity, 2: odd parity, 3: two stop bits; all 4 clocks per bit.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        serial_tx #(
            .CLKS_PER_BIT(4),
            .DATA_BITS   (8),
            .PARITY_EN   ((gi == 1 || gi == 2) ? 1 : 0),
            .PARITY_ODD  ((gi == 2) ? 1 : 0),
            .STOP_BITS   ((gi == 3) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .RESET     (RESET),
            .data_in   (din[gi]),
            .data_valid(dv[gi]),
            .data_ready(rdy_w[gi]),
            .tx        (tx_w[gi]),
            .busy      (busy_w[gi]),
            .done      (done_w[gi])
        );
    end

    task automatic capture(input int k, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_tx[start+i]   = tx_w[k];
            obs_busy[start+i] = busy_w[k];
            obs_done[start+i] = done_w[k];
            obs_rdy[start+i]  = rdy_w[k];
        end
    endtask

    // Presents a byte for one edge; leaves the bench 1 time unit into the first frame cycle.
    task automatic present(input int k, input logic [7:0] b);
        @(negedge clk);
        din[k]  = b;
        dv[k]   = 1'b1;
        acc_rdy = rdy_w[k];
        @(posedge clk);
        #1;
        dv[k]  = 1'b0;
        din[k] = ~b;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        dv    = '0;
        for (int k = 0; k < 4; k++) din[k] = 8'h00;
        #12;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({tx_w[k], busy_w[k], done_w[k], rdy_w[k]} !== 4'b1001) begin
                errors++;
                $display("FAIL reset_state dut%0d: tx/busy/done/ready=%b required 1001",
                         k, {tx_w[k], busy_w[k], done_w[k], rdy_w[k]});
            end
        end
        @(negedge clk);
        RESET = 1'b1;
        capture(0, 0, 2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100) begin
                errors++;
                $display("FAIL reset_release cycle %0d: tx/busy/done=%b required 100",
                         i, {obs_tx[i], obs_busy[i], obs_done[i]});
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        logic [15:0] exp_frame;
        exp_frame = 16'h034A;  // 0,1,0,1,0,0,1,0,1,1 in line order for 0xA5
        present(0, 8'hA5);
        checks++;
        if (acc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: data_ready=%b required 1", acc_rdy);
        end
        capture(0, 0, 42);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_frame[i/4], 2'b10}) begin
                errors++;
                $display("FAIL basic_frame cycle %0d: tx/busy/done=%b required %b",
                         i + 1, {obs_tx[i], obs_busy[i], obs_done[i]}, {exp_frame[i/4], 2'b10});
            end
        end
        checks++;
        if ({obs_tx[40], obs_busy[40], obs_done[40]} !== 3'b101) begin
            errors++;
            $display("FAIL basic_done cycle 41: tx/busy/done=%b required 101",
                     {obs_tx[40], obs_busy[40], obs_done[40]});
        end
        checks++;
        if ({obs_tx[41], obs_busy[41], obs_done[41]} !== 3'b100) begin
            errors++;
            $display("FAIL basic_after_done cycle 42: tx/busy/done=%b required 100",
                     {obs_tx[41], obs_busy[41], obs_done[41]});
        end
        $display("test_basic frame 0xA5 done");
    endtask

    task automatic test_parity;
        int          kk [3];
        logic [7:0]  bb [3];
        logic [15:0] ee [3];
        logic [15:0] e;
        kk = '{1, 2, 1};
        bb = '{8'hA5, 8'hA5, 8'h01};
        ee = '{16'h054A, 16'h074A, 16'h0602};
        for (int v = 0; v < 3; v++) begin
            e = ee[v];
            present(kk[v], bb[v]);
            capture(kk[v], 0, 46);
            for (int i = 0; i < 44; i++) begin
                checks++;
                if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {e[i/4], 2'b10}) begin
                    errors++;
                    $display("FAIL parity_frame vec%0d cycle %0d: tx/busy/done=%b required %b",
                             v, i + 1, {obs_tx[i], obs_busy[i], obs_done[i]}, {e[i/4], 2'b10});
                end
            end
            checks++;
            if ({obs_tx[44], obs_busy[44], obs_done[44]} !== 3'b101) begin
                errors++;
                $display("FAIL parity_done vec%0d: tx/busy/done=%b required 101",
                         v, {obs_tx[44], obs_busy[44], obs_done[44]});
            end
            $display("test_parity vec%0d byte 0x%02h dut%0d done", v, bb[v], kk[v]);
        end
    endtask

    task automatic test_two_stop;
        logic [15:0] exp_frame;
        exp_frame = 16'h074A;
        present(3, 8'hA5);
        capture(3, 0, 46);
        for (int i = 0; i < 44; i++) begin
            checks++;
            if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_frame[i/4], 2'b10}) begin
                errors++;
                $display("FAIL stop2_frame cycle %0d: tx/busy/done=%b required %b",
                         i + 1, {obs_tx[i], obs_busy[i], obs_done[i]}, {exp_frame[i/4], 2'b10});
            end
        end
        checks++;
        if ({obs_tx[44], obs_busy[44], obs_done[44]} !== 3'b101) begin
            errors++;
            $display("FAIL stop2_done cycle 45: tx/busy/done=%b required 101",
                     {obs_tx[44], obs_busy[44], obs_done[44]});
        end
        checks++;
        if (obs_done[45] !== 1'b0) begin
            errors++;
            $display("FAIL stop2_done_width cycle 46: done=%b required 0", obs_done[45]);
        end
        $display("test_two_stop frame 0xA5 done");
    endtask

    task automatic test_back_to_back;
        logic [15:0] f1, f2;
        f1 = 16'h0278;  // 0x3C framed
        f2 = 16'h0386;  // 0xC3 framed
        @(negedge clk);
        din[0] = 8'h3C;
        dv[0]  = 1'b1;
        @(posedge clk);
        #1;
        din[0] = 8'hC3;
        capture(0, 0, 41);
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        capture(0, 41, 42);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({obs_tx[i], obs_busy[i], obs_done[i], obs_rdy[i]} !== {f1[i/4], 3'b100}) begin
                errors++;
                $display("FAIL b2b_frame1 cycle %0d: tx/busy/done/ready=%b required %b",
                         i + 1, {obs_tx[i], obs_busy[i], obs_done[i], obs_rdy[i]}, {f1[i/4], 3'b100});
            end
        end
        checks++;
        if ({obs_tx[40], obs_busy[40], obs_done[40], obs_rdy[40]} !== 4'b1011) begin
            errors++;
            $display("FAIL b2b_gap cycle 41: tx/busy/done/ready=%b required 1011",
                     {obs_tx[40], obs_busy[40], obs_done[40], obs_rdy[40]});
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({obs_tx[41+i], obs_busy[41+i], obs_done[41+i]} !== {f2[i/4], 2'b10}) begin
                errors++;
                $display("FAIL b2b_frame2 cycle %0d: tx/busy/done=%b required %b",
                         i + 42, {obs_tx[41+i], obs_busy[41+i], obs_done[41+i]}, {f2[i/4], 2'b10});
            end
        end
        checks++;
        if ({obs_tx[81], obs_busy[81], obs_done[81], obs_tx[82], obs_busy[82], obs_done[82]} !== 6'b101100) begin
            errors++;
            $display("FAIL b2b_end cycles 82-83: tx/busy/done x2=%b required 101100",
                     {obs_tx[81], obs_busy[81], obs_done[81], obs_tx[82], obs_busy[82], obs_done[82]});
        end
        $display("test_back_to_back 0x3C then 0xC3 done");
    endtask

    task automatic test_ignore_busy;
        logic [15:0] exp_frame;
        exp_frame = 16'h0200;
        present(0, 8'h00);
        capture(0, 0, 10);
        din[0] = 8'hFF;
        dv[0]  = 1'b1;
        capture(0, 10, 2);
        dv[0] = 1'b0;
        capture(0, 12, 40);
        checks++;
        if ({obs_rdy[10], obs_rdy[11]} !== 2'b00) begin
            errors++;
            $display("FAIL ignore_ready: data_ready during pulse=%b required 00", {obs_rdy[10], obs_rdy[11]});
        end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({obs_tx[i], obs_busy[i]} !== {exp_frame[i/4], 1'b1}) begin
                errors++;
                $display("FAIL ignore_frame cycle %0d: tx/busy=%b required %b",
                         i + 1, {obs_tx[i], obs_busy[i]}, {exp_frame[i/4], 1'b1});
            end
        end
        checks++;
        if (obs_done[40] !== 1'b1) begin
            errors++;
            $display("FAIL ignore_done cycle 41: done=%b required 1", obs_done[40]);
        end
        for (int i = 41; i < 52; i++) begin
            checks++;
            if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100) begin
                errors++;
                $display("FAIL ignore_no_second cycle %0d: tx/busy/done=%b required 100",
                         i + 1, {obs_tx[i], obs_busy[i], obs_done[i]});
            end
        end
        $display("test_ignore_busy frame 0x00 with 0xFF pulse done");
    endtask

    task automatic test_reset_mid;
        logic [15:0] exp_frame;
        exp_frame = 16'h02AA;  // 0x55 framed
        present(0, 8'hA5);
        capture(0, 0, 17);     // now in the first cycle of data bit 3
        #1;
        RESET = 1'b0;
        #1;
        checks++;
        if ({tx_w[0], busy_w[0], done_w[0], rdy_w[0]} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_mid_async: tx/busy/done/ready=%b required 1001",
                     {tx_w[0], busy_w[0], done_w[0], rdy_w[0]});
        end
        capture(0, 0, 2);
        RESET = 1'b1;
        capture(0, 2, 3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({obs_tx[i], obs_busy[i], obs_done[i]} !== 3'b100) begin
                errors++;
                $display("FAIL reset_mid_idle step %0d: tx/busy/done=%b required 100",
                         i, {obs_tx[i], obs_busy[i], obs_done[i]});
            end
        end
        present(0, 8'h55);
        checks++;
        if (acc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: data_ready=%b required 1", acc_rdy);
        end
        capture(0, 0, 41);
        for (int i = 0; i < 40; i++) begin
            checks++;
            if ({obs_tx[i], obs_busy[i], obs_done[i]} !== {exp_frame[i/4], 2'b10}) begin
                errors++;
                $display("FAIL reset_mid_frame cycle %0d: tx/busy/done=%b required %b",
                         i + 1, {obs_tx[i], obs_busy[i], obs_done[i]}, {exp_frame[i/4], 2'b10});
            end
        end
        checks++;
        if (obs_done[40] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_done cycle 41: done=%b required 1", obs_done[40]);
        end
        $display("test_reset_mid then frame 0x55 done");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_two_stop;
        test_back_to_back;
        test_ignore_busy;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
